// File: rtl/enter_parking_lot.sv
// Entrance controller for the 8-spot lot: allocates the lowest free spot,
// drives the entry gate for GATE_CYCLES cycles and frees spots on exit.
module enter_parking_lot #(
   parameter int unsigned GATE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_req,
   input  logic [7:0] exit_location,
   output logic [2:0] park_number,
   output logic       entry_grant,
   output logic       entry_deny,
   output logic       gate_open,
   output logic [7:0] occupied,
   output logic       full,
   output logic [3:0] free_count,
   output logic       exit_error
);

   localparam int unsigned SPOTS = 8;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ALLOC   = 3'd1,
      GATE    = 3'd2,
      DENY    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   gate_cnt, gate_cnt_next;
   logic [2:0]         park_next;
   logic               grant_next, deny_next, gate_next;
   logic [2:0]         free_idx;
   logic [SPOTS-1:0]   alloc_mask, exit_mask, occupied_next;
   logic               exit_onehot, exit_valid, exit_err_next;
   logic [3:0]         ones;

   // Lowest-numbered free spot; spot 0 wins
   always_comb begin
      free_idx = '0;
      for (int i = SPOTS - 1; i >= 0; i--) begin
         if (!occupied[i]) free_idx = 3'(i);
      end
   end

   // Occupancy summary derived from the registered map
   always_comb begin
      ones = '0;
      for (int i = 0; i < SPOTS; i++) begin
         ones = ones + 4'(occupied[i]);
      end
      free_count = 4'(SPOTS) - ones;
      full       = &occupied;
   end

   // Next-state and registered-output decode
   always_comb begin
      state_next    = state;
      gate_cnt_next = gate_cnt;
      park_next     = park_number;
      grant_next    = 1'b0;
      deny_next     = 1'b0;
      gate_next     = 1'b0;
      case (state)
         IDLE: begin
            if (entry_req && !full) begin
               park_next  = free_idx;
               state_next = ALLOC;
               grant_next = 1'b1;
            end else if (entry_req) begin
               state_next = DENY;
               deny_next  = 1'b1;
            end
         end
         ALLOC: begin
            gate_cnt_next = CNT_W'(GATE_CYCLES);
            state_next    = GATE;
            gate_next     = 1'b1;
         end
         GATE: begin
            if (gate_cnt == CNT_W'(1)) begin
               state_next = RELEASE;
            end else begin
               gate_cnt_next = gate_cnt - CNT_W'(1);
               gate_next     = 1'b1;
            end
         end
         DENY: state_next = RELEASE;
         RELEASE: begin
            if (!entry_req) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Exit validation and occupancy update; allocation never hits a freed bit
   always_comb begin
      exit_onehot   = (exit_location != '0) &&
                      ((exit_location & (exit_location - SPOTS'(1))) == '0);
      exit_valid    = exit_onehot && ((exit_location & occupied) != '0);
      exit_err_next = (exit_location != '0) && !exit_valid;
      exit_mask     = exit_valid ? exit_location : '0;
      alloc_mask    = (state == ALLOC) ? (SPOTS'(1) << park_number) : '0;
      occupied_next = (occupied & ~exit_mask) | alloc_mask;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gate_cnt    <= '0;
         park_number <= '0;
         entry_grant <= 1'b0;
         entry_deny  <= 1'b0;
         gate_open   <= 1'b0;
         occupied    <= '0;
         exit_error  <= 1'b0;
      end else begin
         state       <= state_next;
         gate_cnt    <= gate_cnt_next;
         park_number <= park_next;
         entry_grant <= grant_next;
         entry_deny  <= deny_next;
         gate_open   <= gate_next;
         occupied    <= occupied_next;
         exit_error  <= exit_err_next;
      end
   end

endmodule

// File: doc/enter_parking_lot.md
Name: enter_parking_lot

Overview:
- Entrance-side controller for the 8-spot parking lot, the counterpart of the exit decoder.
- Tracks occupancy of spots 0..7 and allocates the lowest-numbered free spot to an arriving car.
- Returns the 3-bit park_number to the car and drives the entry gate for a fixed time.
- Accepts the one-hot park_location released by the exit path to free spots.

Parameters:
- GATE_CYCLES, 4, cycles gate_open is held high after a grant; must be 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- entry_req  input  1  car present at entry sensor; level, held until gate cycle completes
- exit_location  input  8  one-hot spot being vacated; all-zero means no exit
- park_number  output  3  spot assigned to the last granted car
- entry_grant  output  1  one-cycle pulse: park_number is newly valid
- entry_deny  output  1  one-cycle pulse: request rejected, lot full
- gate_open  output  1  entry gate drive
- occupied  output  8  occupancy map, bit i = spot i taken
- full  output  1  occupied == 8'hFF
- free_count  output  4  8 minus popcount(occupied), range 0..8
- exit_error  output  1  one-cycle pulse: exit_location invalid

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; occupied=0; park_number=0; gate counter=0; entry_grant, entry_deny, gate_open and exit_error all 0. Combinational outputs at reset: full=0, free_count=8.
- States: IDLE, ALLOC, GATE, DENY, RELEASE.
- IDLE:
  - entry_req=1 and full=0: load park_number with the index of the lowest 0 bit of occupied; go to ALLOC.
  - entry_req=1 and full=1: go to DENY.
  - Otherwise stay in IDLE.
- ALLOC:
  - entry_grant=1 for this single cycle; park_number is valid.
  - On exit, set occupied[park_number] and load the gate counter with GATE_CYCLES. Next state is GATE.
- GATE:
  - gate_open=1; the counter decrements each cycle.
  - When the counter reaches 1, go to RELEASE. gate_open is high for exactly GATE_CYCLES cycles.
- DENY: entry_deny=1 for one cycle; go to RELEASE.
- RELEASE:
  - Wait for entry_req=0, then go to IDLE.
  - This prevents one car from receiving two spots.
- park_number holds its value until the next IDLE→ALLOC transition.
- Grant latency: entry_req high in IDLE at edge N gives entry_grant during cycle N+1, and gate_open during cycles N+2 .. N+1+GATE_CYCLES.
- Exit handling is independent of the FSM and evaluated every cycle:
  - Valid exit: exit_location is one-hot and its bit is set in occupied. Clear that bit at the next edge.
  - Error case: exit_location is non-zero and either not one-hot or addressing a free spot. Assert exit_error for that cycle (registered, visible the next cycle); occupied is unchanged.
  - exit_location=0: no action, no error.
- Simultaneous exit and allocation in the same cycle:
  - occupied_next = (occupied & ~exit_mask) | alloc_mask.
  - Allocation always targets a free bit, so the two masks never collide.
- full is evaluated on registered occupied:
  - An exit in the same cycle as a request on a full lot still produces DENY.
  - The car retries after RELEASE→IDLE.
- Priority encoder: spot 0 has the highest priority; the encoder output is don't-care when full (never used).
- Reset asserted mid-GATE: gate_open drops immediately and all occupancy is lost.

Test Plan:
- Reset, then entry_req=1 held 8 cycles and dropped; repeat 8 times (GATE_CYCLES=4) -> grants with park_number 0,1,…,7; occupied ends 8'hFF; full=1; free_count=0; each gate_open pulse is exactly 4 cycles, starting 2 cycles after the request.
- Lot full, 9th request -> entry_deny pulses once; no grant; gate_open stays 0; FSM waits in RELEASE until entry_req drops.
- occupied=8'hFF; exit_location=8'b00001000 for one cycle; then request -> occupied=8'hF7; free_count=1; new grant gives park_number=3.
- Exit of spot 5 in the same cycle as an ALLOC of spot 2, from occupied=8'b00100011 -> occupied=8'b00000111; no exit_error.
- exit_location=8'b00000101, then exit_location=8'b01000000 with spot 6 free -> exit_error pulses each time; occupied unchanged.
- Assert rst_n=0 during GATE cycle 2 -> gate_open=0 and occupied=0 immediately; after release, next request gets park_number=0.
